// File: rtl/conv_layer_sequencer.sv
// Feeds one Conv2D3x3 featuremap stage from a CHANNELS-wide buffer, flushes the line buffers, counts outputs.
// Optional SEQ_PERF_CNT_EN builds the stall_cycles performance counter.
module conv_layer_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 16,
    parameter int IMG_SIZE   = 208,
    parameter int FLUSH_PIX  = IMG_SIZE + 1,
    parameter int ADDR_W     = $clog2(IMG_SIZE * IMG_SIZE)
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic                           rd_en,
    output logic [ADDR_W-1:0]              rd_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] rd_data,
    input  logic                           out_afull,
    output logic [CHANNELS*DATA_WIDTH-1:0] conv_data,
    output logic                           conv_valid,
    input  logic                           conv_vout,
    output logic [31:0]                    stall_cycles
);
    localparam int TOTAL   = IMG_SIZE * IMG_SIZE;
    localparam int FLUSH_W = $clog2(FLUSH_PIX + 1);
    localparam logic [ADDR_W:0]  PIX_LAST   = (ADDR_W+1)'(TOTAL - 1);
    localparam logic [ADDR_W:0]  OUT_TOTAL  = (ADDR_W+1)'(TOTAL);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_PIX - 1);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, WAIT} state_t;

    state_t                    state;
    logic [ADDR_W:0]           pix_cnt;
    logic [ADDR_W:0]           out_cnt;
    logic [FLUSH_W-1:0]        flush_cnt;
    logic                      feed_rd, flush_issue, vout_live, out_sat, out_last;
    logic                      src_rd;
    logic [CHANNELS*DATA_WIDTH-1:0] data_hold;

    assign feed_rd     = (state == FEED)  && !out_afull;
    assign flush_issue = (state == FLUSH) && !out_afull;
    assign vout_live   = conv_vout && (state != IDLE);
    assign out_sat     = (out_cnt == OUT_TOTAL);
    assign out_last    = vout_live && (out_cnt == PIX_LAST);

    assign rd_en   = feed_rd;
    assign rd_addr = pix_cnt[ADDR_W-1:0];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            flush_cnt <= '0;
            out_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (vout_live) begin
                if (out_sat) err <= 1'b1;
                else         out_cnt <= out_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FEED;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        pix_cnt   <= '0;
                        flush_cnt <= '0;
                        out_cnt   <= '0;
                    end else if (conv_vout) begin
                        err <= 1'b1;
                    end
                end
                FEED: begin
                    if (feed_rd) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == PIX_LAST) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_issue) begin
                        flush_cnt <= flush_cnt + 1'b1;
                        if (flush_cnt == FLUSH_LAST) state <= WAIT;
                    end
                end
                WAIT: begin
                    // out_last lets done follow the final output by one cycle
                    if (out_sat || out_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // rd_data lands one cycle after rd_en, aligned with the registered conv_valid
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            conv_valid <= 1'b0;
            src_rd     <= 1'b0;
            data_hold  <= '0;
        end else begin
            conv_valid <= feed_rd || flush_issue;
            src_rd     <= feed_rd;
            data_hold  <= conv_data;
        end
    end

    assign conv_data = src_rd ? rd_data : (conv_valid ? '0 : data_hold);

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cycles <= '0;
        end else if (state == IDLE && start) begin
            stall_cycles <= '0;
        end else if ((state == FEED || state == FLUSH) && out_afull && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: 4x4 map, 5 flush pixels, 16 lanes, echoing lane model.
module tb_conv_layer_sequencer;
    localparam int DW = 32;
    localparam int CH = 16;
    localparam int IMG = 4;
    localparam int FP = 5;
    localparam int AW = $clog2(IMG * IMG);

    logic           Clk, Rst, start, busy, done, err, rd_en, out_afull, conv_valid, conv_vout;
    logic [AW-1:0]  rd_addr;
    logic [CH*DW-1:0] rd_data, conv_data;
    logic [31:0]    stall_cycles;
    logic           lane_vout, spur_vout;
    int             lane_cnt;
    int             n_total, n_pass;

    conv_layer_sequencer #(.DATA_WIDTH(DW), .CHANNELS(CH), .IMG_SIZE(IMG), .FLUSH_PIX(FP), .ADDR_W(AW)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .out_afull(out_afull),
        .conv_data(conv_data), .conv_valid(conv_valid), .conv_vout(conv_vout),
        .stall_cycles(stall_cycles)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [CH*DW-1:0] pix_word(input int a);
        logic [CH*DW-1:0] w;
        for (int k = 0; k < CH; k++) w[k*DW +: DW] = 32'(a * 256 + k + 1);
        return w;
    endfunction

    // synchronous buffer: data one cycle after rd_en
    always @(posedge Clk) if (rd_en) rd_data <= pix_word(int'(rd_addr));

    // lane model: first FP valid inputs fill the line buffers, the rest each yield one output
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            lane_cnt  <= 0;
            lane_vout <= 1'b0;
        end else begin
            if (start && !busy) lane_cnt <= 0;
            else if (conv_valid) lane_cnt <= lane_cnt + 1;
            lane_vout <= conv_valid && (lane_cnt >= FP);
        end
    end
    assign conv_vout = lane_vout | spur_vout;

    task automatic pulse_start();
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
    endtask

    task automatic wait_addr(input int a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (rd_en && int'(rd_addr) == a) ok = 1'b1;
            else @(negedge Clk);
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        #3;
        n_total++;
        if ({busy, done, err, rd_en, conv_valid} !== 5'b0 || rd_addr !== '0 || stall_cycles !== 32'h0 || conv_data !== '0)
            $display("FAIL reset: busy=%b done=%b err=%b rd_en=%b cv=%b addr=%0d stall=%0d, want all 0",
                     busy, done, err, rd_en, conv_valid, rd_addr, stall_cycles);
        else n_pass++;
        @(negedge Clk); Rst = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_nominal();
        int n_rd, n_val, n_vo, n_done, vo_cyc, done_cyc;
        logic [CH*DW-1:0] exp_d;
        n_rd = 0; n_val = 0; n_vo = 0; n_done = 0; vo_cyc = -1; done_cyc = -1;
        pulse_start();
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (rd_en) begin
                n_total++;
                if (int'(rd_addr) !== n_rd) $display("FAIL nom_addr: got %0d want %0d", rd_addr, n_rd);
                else n_pass++;
                n_rd++;
            end
            if (conv_valid) begin
                exp_d = (n_val < IMG*IMG) ? pix_word(n_val) : '0;
                n_total++;
                if (conv_data !== exp_d) $display("FAIL nom_data[%0d]: got %h want %h", n_val, conv_data[31:0], exp_d[31:0]);
                else n_pass++;
                n_val++;
            end
            if (conv_vout) begin n_vo++; if (n_vo == IMG*IMG) vo_cyc = cyc; end
            if (done) begin n_done++; done_cyc = cyc; end
            @(negedge Clk);
        end
        n_total++;
        if (n_rd != 16 || n_val != 21) $display("FAIL nom_counts: reads=%0d valids=%0d want 16/21", n_rd, n_val);
        else n_pass++;
        n_total++;
        if (n_done != 1 || done_cyc != vo_cyc + 1) $display("FAIL nom_done: pulses=%0d at %0d, last vout %0d, want 1 at vout+1", n_done, done_cyc, vo_cyc);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || err !== 1'b0) $display("FAIL nom_end: busy=%b err=%b want 0/0", busy, err);
        else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] exp_stall;
`ifdef SEQ_PERF_CNT_EN
        exp_stall = 32'd3;
`else
        exp_stall = 32'd0;
`endif
        pulse_start();
        wait_addr(6, ok);
        n_total++;
        if (!ok) $display("FAIL stall_reach: addr 6 not seen, got 0 want 1"); else n_pass++;
        out_afull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (rd_en !== 1'b0) $display("FAIL stall_rd_en[%0d]: got %b want 0", i, rd_en); else n_pass++;
            @(negedge Clk);
        end
        out_afull = 1'b0;
        #1;
        n_total++;
        if (rd_en !== 1'b1 || rd_addr !== AW'(6)) $display("FAIL stall_resume: rd_en=%b addr=%0d want 1/6", rd_en, rd_addr);
        else n_pass++;
        wait_done(ok);
        n_total++;
        if (!ok) $display("FAIL stall_done: got 0 want 1"); else n_pass++;
        @(negedge Clk);
        n_total++;
        if (stall_cycles !== exp_stall) $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, exp_stall);
        else n_pass++;
    endtask

    task automatic test_start_busy();
        bit ok;
        pulse_start();
        wait_addr(8, ok);
        start = 1'b1;
        @(negedge Clk); start = 1'b0;
        n_total++;
        if (!ok || rd_en !== 1'b1 || rd_addr !== AW'(9) || busy !== 1'b1)
            $display("FAIL busy_start_cont: rd_en=%b addr=%0d busy=%b want 1/9/1", rd_en, rd_addr, busy);
        else n_pass++;
        wait_done(ok);
        n_total++;
        if (!ok || err !== 1'b0) $display("FAIL busy_start_done: done=%b err=%b want 1/0", ok, err); else n_pass++;
        @(negedge Clk);
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL busy_start_idle: done=%b busy=%b want 0/0", done, busy);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bit ok;
        pulse_start();
        wait_addr(10, ok);
        #2 Rst = 1'b0;
        #1;
        n_total++;
        if (!ok || {busy, done, err, rd_en, conv_valid} !== 5'b0 || rd_addr !== '0 || conv_data !== '0)
            $display("FAIL arst_outputs: busy=%b done=%b err=%b rd_en=%b cv=%b addr=%0d want all 0",
                     busy, done, err, rd_en, conv_valid, rd_addr);
        else n_pass++;
        @(negedge Clk); Rst = 1'b1;
        @(negedge Clk);
        n_total++;
        if (done !== 1'b0) $display("FAIL arst_no_done: got %b want 0", done); else n_pass++;
        pulse_start();
        n_total++;
        if (rd_en !== 1'b1 || rd_addr !== '0) $display("FAIL arst_restart: rd_en=%b addr=%0d want 1/0", rd_en, rd_addr);
        else n_pass++;
        wait_done(ok);
        n_total++;
        if (!ok) $display("FAIL arst_rerun_done: got 0 want 1"); else n_pass++;
        @(negedge Clk);
    endtask

    task automatic test_spurious();
        bit ok;
        @(negedge Clk); spur_vout = 1'b1;
        @(negedge Clk); spur_vout = 1'b0;
        n_total++;
        if (err !== 1'b1) $display("FAIL spur_set: err got %b want 1", err); else n_pass++;
        repeat (3) @(negedge Clk);
        n_total++;
        if (err !== 1'b1) $display("FAIL spur_hold: err got %b want 1", err); else n_pass++;
        pulse_start();
        n_total++;
        if (err !== 1'b0 || busy !== 1'b1) $display("FAIL spur_clear: err=%b busy=%b want 0/1", err, busy); else n_pass++;
        wait_done(ok);
        n_total++;
        if (!ok || err !== 1'b0) $display("FAIL spur_run: done=%b err=%b want 1/0", ok, err); else n_pass++;
    endtask

    initial begin
        n_total = 0; n_pass = 0;
        Rst = 1'b0; start = 1'b0; out_afull = 1'b0; spur_vout = 1'b0;
        test_reset();
        test_nominal();
        test_stall();
        test_start_busy();
        test_async_reset();
        test_spurious();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
